// File: rtl/spare_row_pkg.sv
// Shared types and sizes for the spare-row allocator.
//   E_W      : width of one spare-row entry {blk, addr}
//   entry_t  : packed entry; blk sits in the upper bits, addr in the lower
//   state_t  : allocator FSM states
//   CNT_W    : per-entry hit counter width (SPARE_ROW_HITCNT_EN builds only)
package spare_row_pkg;

   localparam int N_SPARE_DEF = 4;
   localparam int ADDR_W      = 10;
   localparam int BLK_W       = 2;
   localparam int E_W         = BLK_W + ADDR_W;
   localparam int CNT_W       = 4;

   typedef struct packed {
      logic [BLK_W-1:0]  blk;
      logic [ADDR_W-1:0] addr;
   } entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      ALLOC = 2'd2,
      FULL  = 2'd3
   } state_t;

endpackage

// File: rtl/spare_free_pick.sv
// Lowest-free spare picker (purely combinational).
//   rlss     in  : entry valid bits
//   free_idx out : lowest index whose rlss bit is clear (0 when none is free)
//   all_full out : every entry is valid
module spare_free_pick
   import spare_row_pkg::*;
#(
   parameter int N     = N_SPARE_DEF,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     rlss,
   output logic [IDX_W-1:0] free_idx,
   output logic             all_full
);

   // Scan from the top down so the lowest free index is the last one written.
   always_comb begin
      free_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!rlss[i]) free_idx = IDX_W'(i);
      end
   end

   assign all_full = &rlss;

endmodule

// File: rtl/spare_row_alloc.sv
// Spare-row allocator: writer side of the BIRA spare-row register set.
// Faulty rows arrive over a valid/ready handshake, are matched against the
// allocated entries and, on a miss, take the lowest free spare.
//
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   clr         : synchronous clear, overrides everything else
//   flt_valid/flt_ready/flt_row : fault handshake, flt_row = {block, addr}
//   rrx         : entry i at [i*E_W +: E_W]
//   rlss        : bit i = entry i valid
//   used_cnt    : number of valid entries
//   hit         : pulse, checked fault matched a valid entry
//   alloc_done  : pulse, entry being written this cycle
//   overflow    : sticky, a fault missed with no spare left
//   hit_cnt     : per-entry saturating hit counters (only with
//                 SPARE_ROW_HITCNT_EN defined)
//
// Build option: `define SPARE_ROW_HITCNT_EN to add the hit counters.
module spare_row_alloc
   import spare_row_pkg::*;
#(
   parameter int N_SPARE = N_SPARE_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   flt_valid,
   output logic                   flt_ready,
   input  logic [E_W-1:0]         flt_row,
   output logic [N_SPARE*E_W-1:0] rrx,
   output logic [N_SPARE-1:0]     rlss,
   output logic [2:0]             used_cnt,
   output logic                   hit,
   output logic                   alloc_done,
   output logic                   overflow
`ifdef SPARE_ROW_HITCNT_EN
   ,
   output logic [N_SPARE*CNT_W-1:0] hit_cnt
`endif
);

   localparam int IDX_W = (N_SPARE > 1) ? $clog2(N_SPARE) : 1;

   state_t                   state, state_nx;
   entry_t                   flt_q;
   entry_t [N_SPARE-1:0]     ent;
   logic   [N_SPARE-1:0]     vld;
   logic   [2:0]             used;
   logic                     ovf;
   logic                     full_chk;
   logic   [N_SPARE-1:0]     match_vec;
   logic                     any_match;
   logic                     take;
   logic   [IDX_W-1:0]       free_idx;
   logic                     all_full;

   spare_free_pick #(
      .N     (N_SPARE),
      .IDX_W (IDX_W)
   ) u_pick (
      .rlss     (vld),
      .free_idx (free_idx),
      .all_full (all_full)
   );

   // Full E_W compare: block bits take part, so equal addr in another block misses.
   always_comb begin
      for (int i = 0; i < N_SPARE; i++) begin
         match_vec[i] = vld[i] && (ent[i] == flt_q);
      end
   end

   assign any_match = |match_vec;
   assign take      = flt_valid && flt_ready;

   always_comb begin
      state_nx   = state;
      flt_ready  = 1'b0;
      hit        = 1'b0;
      alloc_done = 1'b0;
      case (state)
         IDLE: begin
            flt_ready = 1'b1;
            if (flt_valid) state_nx = CHECK;
         end
         CHECK: begin
            if (any_match) begin
               hit      = 1'b1;
               state_nx = IDLE;
            end else if (all_full) begin
               state_nx = FULL;
            end else begin
               state_nx = ALLOC;
            end
         end
         ALLOC: begin
            alloc_done = 1'b1;
            state_nx   = IDLE;
         end
         FULL: begin
            // Faults keep flowing while full; only the match result is reported.
            flt_ready = 1'b1;
            hit       = full_chk && any_match;
         end
         default: state_nx = IDLE;
      endcase
      if (clr) begin
         state_nx   = IDLE;
         flt_ready  = 1'b0;
         hit        = 1'b0;
         alloc_done = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         flt_q    <= '0;
         ent      <= '0;
         vld      <= '0;
         used     <= '0;
         ovf      <= 1'b0;
         full_chk <= 1'b0;
      end else if (clr) begin
         state    <= IDLE;
         flt_q    <= '0;
         ent      <= '0;
         vld      <= '0;
         used     <= '0;
         ovf      <= 1'b0;
         full_chk <= 1'b0;
      end else begin
         state <= state_nx;
         if (take) flt_q <= flt_row;
         // A fault accepted in FULL is checked in the following cycle.
         full_chk <= (state == FULL) && take;
         if (state == CHECK && !any_match && all_full) ovf <= 1'b1;
         if (state == ALLOC) begin
            ent[free_idx] <= flt_q;
            vld[free_idx] <= 1'b1;
            used          <= used + 3'd1;
         end
      end
   end

   assign rrx      = ent;
   assign rlss     = vld;
   assign used_cnt = used;
   assign overflow = ovf;

`ifdef SPARE_ROW_HITCNT_EN
   logic [N_SPARE-1:0][CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (state == ALLOC) begin
         cnt[free_idx] <= CNT_W'(1);
      end else if (hit) begin
         for (int i = 0; i < N_SPARE; i++) begin
            if (match_vec[i] && (cnt[i] != {CNT_W{1'b1}})) cnt[i] <= cnt[i] + CNT_W'(1);
         end
      end
   end

   assign hit_cnt = cnt;
`endif

endmodule

// File: tb/tb_spare_row_alloc.sv
module tb_spare_row_alloc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr;
   logic        flt_valid;
   logic        flt_ready;
   logic [11:0] flt_row;
   logic [47:0] rrx;
   logic [3:0]  rlss;
   logic [2:0]  used_cnt;
   logic        hit;
   logic        alloc_done;
   logic        overflow;
`ifdef SPARE_ROW_HITCNT_EN
   logic [15:0] hit_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   // Reference model: allocated rows in allocation order (= entry index).
   logic [11:0] m_ent[$];
   bit          m_ovf;

   spare_row_alloc dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .flt_valid  (flt_valid),
      .flt_ready  (flt_ready),
      .flt_row    (flt_row),
      .rrx        (rrx),
      .rlss       (rlss),
      .used_cnt   (used_cnt),
      .hit        (hit),
      .alloc_done (alloc_done),
      .overflow   (overflow)
`ifdef SPARE_ROW_HITCNT_EN
      ,
      .hit_cnt    (hit_cnt)
`endif
   );

   always #5 clk = ~clk;

   wire [55:0] dut_view = {rrx, rlss, used_cnt, overflow};

   function automatic logic [55:0] exp_view();
      logic [47:0] r = '0;
      logic [3:0]  v = '0;
      foreach (m_ent[i]) begin
         r[i*12 +: 12] = m_ent[i];
         v[i]          = 1'b1;
      end
      return {r, v, 3'(m_ent.size()), m_ovf};
   endfunction

   // 0 = hit, 1 = allocate, 2 = miss with no spare left
   function automatic int model_apply(input logic [11:0] row);
      foreach (m_ent[i]) if (m_ent[i] == row) return 0;
      if (m_ent.size() < 4) begin
         m_ent.push_back(row);
         return 1;
      end
      m_ovf = 1'b1;
      return 2;
   endfunction

   function automatic void model_clear();
      m_ent.delete();
      m_ovf = 1'b0;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_clear();
   endtask

   // One fault transaction; hv/av hold hit/alloc_done seen at the 1st..3rd
   // negedge after the handshake edge.
   task automatic send(input logic [11:0] row, output logic [2:0] hv, output logic [2:0] av);
      int n = 0;
      hv = '0;
      av = '0;
      @(negedge clk);
      while (!flt_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!flt_ready) begin
         failures++;
         $display("FAIL send_ready_timeout row=%h flt_ready=%b required=1", row, flt_ready);
      end
      flt_valid = 1'b1;
      flt_row   = row;
      @(posedge clk);
      #1 flt_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         hv[k] = hit;
         av[k] = alloc_done;
      end
   endtask

   task automatic check_txn(input string tag, input logic [11:0] row);
      logic [2:0] hv, av, eh, ea;
      int oc;
      send(row, hv, av);
      oc = model_apply(row);
      eh = (oc == 0) ? 3'b001 : 3'b000;
      ea = (oc == 1) ? 3'b010 : 3'b000;
      checks++;
      if (hv !== eh) begin
         failures++;
         $display("FAIL %s_hit row=%h got=%b required=%b", tag, row, hv, eh);
      end
      checks++;
      if (av !== ea) begin
         failures++;
         $display("FAIL %s_alloc row=%h got=%b required=%b", tag, row, av, ea);
      end
      checks++;
      if (dut_view !== exp_view()) begin
         failures++;
         $display("FAIL %s_state row=%h got=%h required=%h", tag, row, dut_view, exp_view());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clr = 1'b0; flt_valid = 1'b0; flt_row = '0;
      model_clear();
      repeat (3) @(negedge clk);
      checks++;
      if ({dut_view, hit, alloc_done} !== 58'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h required=0", {dut_view, hit, alloc_done});
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (flt_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready got=%b required=1", flt_ready);
      end
   endtask

   task automatic test_alloc_hit();
      check_txn("first_alloc", 12'h805);
      check_txn("repeat_hit", 12'h805);
      check_txn("block_bits", 12'h005);
   endtask

   task automatic test_fill_overflow();
      do_reset();
      for (int i = 1; i <= 4; i++) check_txn("fill", 12'(i));
      checks++;
      if ({flt_ready, overflow, rlss} !== 6'b10_1111) begin
         failures++;
         $display("FAIL fill_idle got=%b required=101111", {flt_ready, overflow, rlss});
      end
      check_txn("overflow_miss", 12'h3FF);
      checks++;
      if ({flt_ready, overflow} !== 2'b11) begin
         failures++;
         $display("FAIL full_ready got=%b required=11", {flt_ready, overflow});
      end
      check_txn("full_hit", 12'h002);
   endtask

   // While full, a fault can be accepted every cycle; each one reports one cycle later.
   task automatic test_back_to_back();
      logic [11:0] rows[6];
      rows = '{12'h001, 12'h777, 12'h004, 12'h004, 12'h9A0, 12'h002};
      @(negedge clk);
      for (int j = 0; j < 6; j++) begin
         flt_valid = 1'b1;
         flt_row   = rows[j];
         @(negedge clk);
         checks++;
         if (hit !== (model_apply(rows[j]) == 0)) begin
            failures++;
            $display("FAIL b2b_hit[%0d] row=%h got=%b required=%b", j, rows[j], hit, !hit);
         end
      end
      flt_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({dut_view, flt_ready} !== {exp_view(), 1'b1}) begin
         failures++;
         $display("FAIL b2b_state got=%h required=%h", {dut_view, flt_ready}, {exp_view(), 1'b1});
      end
   endtask

   task automatic test_clr_collision();
      @(negedge clk);
      clr       = 1'b1;
      flt_valid = 1'b1;
      flt_row   = 12'h123;
      #1;
      checks++;
      if (flt_ready !== 1'b0) begin
         failures++;
         $display("FAIL clr_ready got=%b required=0", flt_ready);
      end
      @(posedge clk);
      #1 clr = 1'b0; flt_valid = 1'b0;
      model_clear();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if ({dut_view, hit, alloc_done} !== {exp_view(), 2'b00}) begin
            failures++;
            $display("FAIL clr_state[%0d] got=%h required=%h", k, {dut_view, hit, alloc_done}, {exp_view(), 2'b00});
         end
      end
   endtask

   task automatic test_random();
      logic [11:0] pool[6];
      foreach (pool[i]) pool[i] = 12'($urandom);
      pool[1] = {~pool[0][11:10], pool[0][9:0]};
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 11) == 0) begin
            @(negedge clk);
            clr = 1'b1;
            @(posedge clk);
            #1 clr = 1'b0;
            model_clear();
         end
         check_txn("rand", pool[$urandom_range(0, 5)]);
      end
   endtask

`ifdef SPARE_ROW_HITCNT_EN
   task automatic test_hitcnt();
      logic [2:0] hv, av;
      do_reset();
      send(12'h010, hv, av);
      checks++;
      if (hit_cnt !== 16'h0001) begin
         failures++;
         $display("FAIL hitcnt_alloc got=%h required=0001", hit_cnt);
      end
      for (int n = 1; n <= 20; n++) begin
         send(12'h010, hv, av);
         if (n == 5 || n == 20) begin
            checks++;
            if (hit_cnt !== 16'((n + 1 > 15) ? 15 : n + 1)) begin
               failures++;
               $display("FAIL hitcnt_%0d got=%h required=%h", n, hit_cnt, 16'((n + 1 > 15) ? 15 : n + 1));
            end
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_alloc_hit();
      test_fill_overflow();
      test_back_to_back();
      test_clr_collision();
      test_random();
`ifdef SPARE_ROW_HITCNT_EN
      test_hitcnt();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spare_row_alloc.md
Name: spare_row_alloc

Overview:
Spare-row allocator for the BIRA flow; it is the writer side of the spare-row register set.
- Accepts faulty row addresses {block[1:0], addr[9:0]} over a valid/ready handshake.
- Checks each fault against already-allocated spare rows and allocates the lowest free spare on a miss.
- Drives the RRx entry and RLSS valid-bit buses that the new-pivot comparators read.
- Flags overflow when a fault needs a spare and none is left.

Parameters:
N_SPARE, 4, number of spare-row entries (RLSS width).
ADDR_W, 10, row address width inside a block.
BLK_W, 2, block select width; entry width E_W = BLK_W+ADDR_W = 12.
CNT_W, 4, per-entry hit counter width (optional feature only).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
clr  in  1  synchronous clear at test start; highest priority.
flt_valid  in  1  fault address valid.
flt_ready  out  1  allocator can accept a fault.
flt_row  in  E_W  faulty row {block, addr}.
rrx  out  N_SPARE*E_W  entry i at [i*E_W +: E_W]; entry 0 feeds RRx1.
rlss  out  N_SPARE  bit i = entry i allocated/valid.
used_cnt  out  3  number of allocated entries, 0..N_SPARE.
hit  out  1  one-cycle pulse: fault matched a valid entry.
alloc_done  out  1  one-cycle pulse: new entry written.
overflow  out  1  sticky: a fault missed while all entries were valid.
hit_cnt  out  N_SPARE*CNT_W  only when SPARE_ROW_HITCNT_EN is defined.

Behaviour:
- Reset (rst_n=0, async) and clr=1 (sync) give the same state:
  - rrx=0, rlss=0, used_cnt=0, hit=0, alloc_done=0, overflow=0, state=IDLE.
  - clr also forces flt_ready=0 in that cycle and discards any captured fault.
- Match rule: entry i matches when rlss[i]=1 and rrx[i] equals flt_q on all E_W bits, i.e. block and addr both equal.
- FSM states: IDLE, CHECK, ALLOC, FULL.
- IDLE:
  - flt_ready=1.
  - On flt_valid & flt_ready, flt_row is captured into flt_q and the FSM goes to CHECK.
- CHECK (flt_ready=0):
  - Any match: hit pulses this cycle; go to IDLE.
  - Miss and used_cnt<N_SPARE: go to ALLOC.
  - Miss and used_cnt==N_SPARE: overflow:=1; go to FULL.
- ALLOC (flt_ready=0):
  - Select the lowest index i with rlss[i]=0.
  - At the clock edge: rrx[i]:=flt_q, rlss[i]:=1, used_cnt+=1. alloc_done pulses during ALLOC.
  - Go to IDLE.
- FULL:
  - flt_ready=1. Every accepted fault is still checked: a match gives hit one cycle later.
  - A miss changes no state; overflow remains set.
  - Only clr or rst_n leaves FULL.
- Latency from the handshake edge:
  - hit appears 1 cycle later.
  - alloc_done appears 2 cycles later; the new rrx/rlss are visible the cycle after alloc_done.
  - Peak throughput: 1 fault per 2 cycles on a hit, per 3 cycles on an allocation.
- Allocating the last free entry returns the FSM to IDLE, not FULL. FULL is entered only on a subsequent miss.
- Entries are never deallocated. rlss is monotonic between clears.
- Identical back-to-back faults: the second one hits and never allocates twice.
- clr in the same cycle as a handshake: clr wins and the fault is dropped (flt_ready=0 in that cycle).

Optional Feature:
SPARE_ROW_HITCNT_EN
- Defined:
  - Each entry keeps a CNT_W-bit saturating counter, set to 1 on allocation and incremented on each hit to that entry.
  - Counter saturates at 2^CNT_W-1.
  - Cleared by reset and clr; exposed on hit_cnt.
- Undefined: no counters and no hit_cnt port; all other behaviour is identical.

Decomposition:
- Package spare_row_pkg holds:
  - E_W and the entry struct {blk, addr};
  - the FSM state enum {IDLE, CHECK, ALLOC, FULL};
  - the N_SPARE default.
- One sub-module, spare_free_pick: combinational lowest-free-index priority encoder over rlss, plus an all-full flag.
- Match logic stays inline.

Test Plan:
- Reset, then fault 0x805 → alloc_done 2 cycles after the handshake; rrx entry0=0x805, rlss=0001, used_cnt=1.
- Fault 0x805 again → hit 1 cycle after the handshake; rlss is unchanged; no alloc_done.
- Fault 0x005 (same addr, block 0) after 0x805 → miss; entry1=0x005, rlss=0011. Confirms the block bits participate in the match.
- Faults 0x001, 0x002, 0x003, 0x004 → rlss=1111, state IDLE, overflow=0. Then 0x3FF → overflow=1, state FULL, flt_ready=1. Then 0x002 → hit pulses.
- clr asserted in the same cycle as flt_valid with 0x123 → flt_ready=0, fault dropped; next cycle rlss=0, used_cnt=0, overflow=0.
- With SPARE_ROW_HITCNT_EN: allocate 0x010, then send 0x010 twenty times → hit_cnt entry0 saturates at 15.
